ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, RAM address width (64 locations).
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_a / req_b  input  1  access request from requester A / B.
REQ-006 wr_a / wr_b  input  1  1 = write, 0 = read; valid while req high.
REQ-007 addr_a / addr_b  input  ADDR_W  access address; valid while req high.
REQ-008 wdata_a / wdata_b  input  DATA_W  write data; valid while req high and wr high.
REQ-009 ack_a / ack_b  output  1  one-cycle pulse: command issued to RAM.
REQ-010 rvalid_a / rvalid_b  output  1  one-cycle pulse: rdata holds the requester's read result.
REQ-011 rdata  output  DATA_W  read data, shared by both requesters, qualified by rvalid_x.
REQ-012 ram_en / ram_wr  output  1  RAM enable / write-enable to s_port_ram en / wr.
REQ-013 ram_addr  output  ADDR_W  RAM address; ram_wdata  output  DATA_W  RAM write data.
REQ-014 ram_rdata  input  DATA_W  RAM registered read data (s_port_ram outdata).

Function
REQ-015 The block SHALL issue at most one RAM command per cycle; all ram_* outputs and ack_x SHALL be registered.
REQ-016 Requester x is eligible in a cycle when req_x = 1 and ack_x = 0 in that cycle.
REQ-017 With one eligible requester, it SHALL be granted; with two, the one indicated by the round-robin pointer SHALL be granted.
REQ-018 Round-robin pointer SHALL point to the requester not granted most recently; reset value points to A; unchanged in cycles with no grant.
REQ-019 A grant sampled at edge N SHALL produce, from edge N until edge N+1: ram_en = 1, ram_wr/addr/wdata copied from the winner, ack of the winner = 1.
REQ-020 In cycles with no grant ram_en and ram_wr SHALL be 0; ram_addr and ram_wdata hold their last values.
REQ-021 Requester contract: inputs stable while req high and ack low; a new transaction may be presented in the cycle after ack.
REQ-022 A read issued at edge N SHALL produce rvalid of the issuing requester at edge N+1 for exactly one cycle, rdata = ram_rdata in that cycle.
REQ-023 A write SHALL raise no rvalid; ack is the sole completion indication.
REQ-024 Read tag (issuer id + read flag) SHALL be a one-deep pipeline register; back-to-back reads by alternating requesters SHALL each return correctly.
REQ-025 Two continuously requesting masters SHALL be granted alternately, one command every cycle (100 % RAM utilisation).
REQ-026 A single continuously requesting master SHALL be granted every other cycle (REQ-016 bubble).
REQ-027 rvalid_a and rvalid_b SHALL never be high in the same cycle; ack_a and ack_b SHALL never be high in the same cycle.

Reset
REQ-028 While rst = 1 at a rising edge: ram_en, ram_wr, ack_a, ack_b, rvalid_a, rvalid_b = 0; ram_addr, ram_wdata = 0; pointer = A; read tag cleared.
REQ-029 Reset mid-operation SHALL discard an in-flight read: no rvalid in the cycle after reset is released.
REQ-030 Requests held through reset SHALL be arbitrated normally from the first edge with rst = 0.

Structure
REQ-031 Shared package ram_arb_pkg SHALL hold ADDR_W/DATA_W defaults and requester id constants (REQ_A = 0, REQ_B = 1).
REQ-032 The two-way round-robin pick (eligibility in, winner + next pointer out) SHALL be a combinational sub-module rr_arb2; pointer register stays in ram_arbiter.

Verification
REQ-033 A writes 0xAA to 0x0A alone -> ack_a one cycle, ram_en=1 ram_wr=1 ram_addr=0x0A ram_wdata=0xAA that cycle, no rvalid.
REQ-034 A and B request in the same cycle after reset (A write 0xAB @0x0C, B read @0x0A after 0x0A=0xAA) -> A acked first, B next cycle; rvalid_b one cycle later with rdata=0xAA.
REQ-035 A and B both read continuously, 8 cycles -> acks alternate A,B,A,B; ram_en high every cycle; each rvalid matches preloaded data at its address.
REQ-036 Only B requests reads continuously -> ack_b every other cycle, ram_en duty 50 %.
REQ-037 rst asserted in the cycle after A's read is issued -> no rvalid_a after reset; all outputs 0; next grant goes to A when both request.
REQ-038 Scoreboard over 1000 random cycles against 64x8 model of s_port_ram -> every read returns last written value; REQ-027 never violated.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester single-port RAM arbiter.
package ram_arb_pkg;
   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 8;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

   // Identifies which requester owns the read currently inside the RAM.
   typedef struct packed {
      logic    vld;
      req_id_e id;
   } rd_tag_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle: both requesters' command/handshake lines plus shared read data.
interface ram_arbiter_if import ram_arb_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              req_a, req_b;
   logic              wr_a, wr_b;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic [DATA_W-1:0] wdata_a, wdata_b;
   logic              ack_a, ack_b;
   logic              rvalid_a, rvalid_b;
   logic [DATA_W-1:0] rdata;

   modport slave (
      input  req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b,
      output ack_a, ack_b, rvalid_a, rvalid_b, rdata
   );

   modport master (
      output req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b,
      input  ack_a, ack_b, rvalid_a, rvalid_b, rdata
   );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; the pointer register lives in the caller.
module rr_arb2 import ram_arb_pkg::*; (
   input  logic [1:0] elig,
   input  req_id_e    ptr,
   output logic       gnt_vld,
   output req_id_e    gnt_id,
   output req_id_e    ptr_nxt
);
   always_comb begin
      gnt_vld = |elig;
      gnt_id  = REQ_A;
      case (elig)
         2'b01:   gnt_id = REQ_A;
         2'b10:   gnt_id = REQ_B;
         2'b11:   gnt_id = ptr;
         default: gnt_id = REQ_A;
      endcase
      // Pointer favours whoever did not just win.
      ptr_nxt = (gnt_id == REQ_A) ? REQ_B : REQ_A;
   end
endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one registered single-port RAM, one command per cycle,
// and routes each read result back to its issuer one cycle after the command.
module ram_arbiter import ram_arb_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   ram_arbiter_if.slave      bus,
   output logic              ram_en,
   output logic              ram_wr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   logic              ram_en_q, ram_en_d;
   logic              ram_wr_q, ram_wr_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic [1:0]        ack_q, ack_d;
   logic [1:0]        rvalid_q, rvalid_d;
   req_id_e           ptr_q, ptr_d;
   rd_tag_t           tag_q, tag_d;

   logic [1:0]        elig;
   logic              gnt_vld;
   req_id_e           gnt_id, ptr_nxt;
   logic              sel_wr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // A requester is blocked in its own ack cycle so it can swap in its next command.
   assign elig = {bus.req_b & ~ack_q[1], bus.req_a & ~ack_q[0]};

   rr_arb2 u_rr (
      .elig    (elig),
      .ptr     (ptr_q),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id),
      .ptr_nxt (ptr_nxt)
   );

   assign sel_wr    = (gnt_id == REQ_B) ? bus.wr_b    : bus.wr_a;
   assign sel_addr  = (gnt_id == REQ_B) ? bus.addr_b  : bus.addr_a;
   assign sel_wdata = (gnt_id == REQ_B) ? bus.wdata_b : bus.wdata_a;

   always_comb begin
      ram_en_d    = 1'b0;
      ram_wr_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ack_d       = 2'b00;
      ptr_d       = ptr_q;
      tag_d       = '{vld: 1'b0, id: REQ_A};
      rvalid_d    = 2'b00;
      if (gnt_vld) begin
         ram_en_d    = 1'b1;
         ram_wr_d    = sel_wr;
         ram_addr_d  = sel_addr;
         ram_wdata_d = sel_wdata;
         ack_d       = (gnt_id == REQ_B) ? 2'b10 : 2'b01;
         ptr_d       = ptr_nxt;
         tag_d       = '{vld: ~sel_wr, id: gnt_id};
      end
      // RAM output is registered, so the result lines up with the cycle after issue.
      if (tag_q.vld)
         rvalid_d = (tag_q.id == REQ_B) ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_en_q    <= 1'b0;
         ram_wr_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ack_q       <= 2'b00;
         rvalid_q    <= 2'b00;
         ptr_q       <= REQ_A;
         tag_q       <= '{vld: 1'b0, id: REQ_A};
      end else begin
         ram_en_q    <= ram_en_d;
         ram_wr_q    <= ram_wr_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ack_q       <= ack_d;
         rvalid_q    <= rvalid_d;
         ptr_q       <= ptr_d;
         tag_q       <= tag_d;
      end
   end

   assign ram_en       = ram_en_q;
   assign ram_wr       = ram_wr_q;
   assign ram_addr     = ram_addr_q;
   assign ram_wdata    = ram_wdata_q;
   assign bus.ack_a    = ack_q[0];
   assign bus.ack_b    = ack_q[1];
   assign bus.rvalid_a = rvalid_q[0];
   assign bus.rvalid_b = rvalid_q[1];
   assign bus.rdata    = ram_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed + random bench for ram_arbiter with a behavioural RAM and a scoreboard model.
module tb_ram_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ram_en, ram_wr;
   logic [5:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata = 8'h00;
   logic [7:0] ram_mem [64];

   ram_arbiter_if #(.ADDR_W(6), .DATA_W(8)) bus ();

   ram_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .ram_en    (ram_en),
      .ram_wr    (ram_wr),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   // Single-port RAM with registered read output.
   always @(posedge clk)
      if (ram_en) begin
         if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= ram_mem[ram_addr];
      end

   // Requester drive state, index 0 = A, 1 = B.
   logic       r_req [2];
   logic       r_wr  [2];
   logic [5:0] r_addr[2];
   logic [7:0] r_wd  [2];
   assign bus.req_a = r_req[0];   assign bus.req_b = r_req[1];
   assign bus.wr_a  = r_wr[0];    assign bus.wr_b  = r_wr[1];
   assign bus.addr_a = r_addr[0]; assign bus.addr_b = r_addr[1];
   assign bus.wdata_a = r_wd[0];  assign bus.wdata_b = r_wd[1];

   // Reference model: expected outputs, shadow memory, queue of promised read results.
   typedef struct { int due; int id; logic [7:0] data; } rd_t;
   rd_t        rdq[$];
   logic [7:0] shadow [64];
   logic       e_ack [2];
   logic       e_en, e_wr;
   logic [5:0] e_addr;
   logic [7:0] e_wd;
   int         last_gnt;
   int         edge_n = 0;
   int         n_chk = 0, n_pass = 0, n_fail = 0;
   int         n_ack_obs [2];
   int         n_en_obs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   // Expected effect of the upcoming rising edge, from the current inputs.
   task automatic predict();
      int win;
      bit ea, eb;
      if (rst) begin
         e_ack[0] = 0; e_ack[1] = 0; e_en = 0; e_wr = 0; e_addr = 0; e_wd = 0;
         last_gnt = 1;
         rdq.delete();
         return;
      end
      ea = r_req[0] && !e_ack[0];
      eb = r_req[1] && !e_ack[1];
      if (ea && eb) win = (last_gnt == 1) ? 0 : 1;
      else if (ea)  win = 0;
      else if (eb)  win = 1;
      else          win = -1;
      e_ack[0] = (win == 0);
      e_ack[1] = (win == 1);
      e_en = (win >= 0);
      e_wr = 0;
      if (win >= 0) begin
         e_wr   = r_wr[win];
         e_addr = r_addr[win];
         e_wd   = r_wd[win];
         if (r_wr[win]) shadow[r_addr[win]] = r_wd[win];
         else rdq.push_back('{due: edge_n + 2, id: win, data: shadow[r_addr[win]]});
         last_gnt = win;
      end
   endtask

   task automatic compare();
      logic [1:0] exp_rv;
      exp_rv = 2'b00;
      chk("ack_a", bus.ack_a, e_ack[0]);
      chk("ack_b", bus.ack_b, e_ack[1]);
      chk("ram_en", ram_en, e_en);
      chk("ram_wr", ram_wr, e_wr);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_wd);
      if (rdq.size() > 0 && rdq[0].due == edge_n) begin
         if (rdq[0].id == 0) exp_rv[0] = 1'b1; else exp_rv[1] = 1'b1;
         if (bus.rvalid_a || bus.rvalid_b) chk("rdata", bus.rdata, rdq[0].data);
         void'(rdq.pop_front());
      end
      chk("rvalid_a", bus.rvalid_a, exp_rv[0]);
      chk("rvalid_b", bus.rvalid_b, exp_rv[1]);
      chk("excl", {bus.ack_a & bus.ack_b, bus.rvalid_a & bus.rvalid_b}, 2'b00);
   endtask

   task automatic tick();
      predict();
      @(posedge clk);
      #1;
      edge_n++;
      compare();
   endtask

   // mode: 0 idle, 1 continuous reads, 2 random, 3 continuous writes
   task automatic gen(input int x, input int mode, input int base, inout int cnt);
      case (mode)
         1: begin r_req[x] = 1; r_wr[x] = 0; r_addr[x] = 6'(base + cnt); cnt++; end
         3: begin
            r_req[x] = 1; r_wr[x] = 1; r_addr[x] = 6'(base + cnt);
            r_wd[x] = 8'hC0 | 8'(base + cnt); cnt++;
         end
         2: begin
            r_req[x]  = ($urandom_range(0, 3) != 0);
            r_wr[x]   = 1'($urandom_range(0, 1));
            r_addr[x] = 6'($urandom_range(0, 7));
            r_wd[x]   = 8'($urandom_range(0, 255));
         end
         default: r_req[x] = 0;
      endcase
   endtask

   // Requesters present a new command in the cycle after their ack.
   task automatic run(input int n, input int ma, input int mb, input int ba, input int bb);
      int  mode[2], base[2], cnt[2];
      bit  cur[2], was[2];
      mode[0] = ma; mode[1] = mb; base[0] = ba; base[1] = bb;
      cnt[0] = 0; cnt[1] = 0; cur[0] = 0; cur[1] = 0; was[0] = 0; was[1] = 0;
      n_ack_obs[0] = 0; n_ack_obs[1] = 0; n_en_obs = 0;
      for (int i = 0; i < n; i++) begin
         for (int x = 0; x < 2; x++)
            if (i == 0 || was[x] || (mode[x] == 2 && !r_req[x] && !cur[x] && $urandom_range(0, 1) == 1))
               gen(x, mode[x], base[x], cnt[x]);
         tick();
         n_ack_obs[0] += int'(bus.ack_a);
         n_ack_obs[1] += int'(bus.ack_b);
         n_en_obs     += int'(ram_en);
         for (int x = 0; x < 2; x++) begin
            was[x] = cur[x];
            cur[x] = e_ack[x];
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin ram_mem[i] = 8'h00; shadow[i] = 8'h00; end
      for (int x = 0; x < 2; x++) begin r_req[x] = 0; r_wr[x] = 0; r_addr[x] = 0; r_wd[x] = 0; end

      // Reset state
      rst = 1; tick(); tick();
      chk("rst_addr", ram_addr, 6'h00);
      chk("rst_ack_a", bus.ack_a, 1'b0);
      rst = 0;

      // Lone write by A
      r_req[0] = 1; r_wr[0] = 1; r_addr[0] = 6'h0A; r_wd[0] = 8'hAA;
      tick();
      chk("w_ack_a", bus.ack_a, 1'b1);
      chk("w_en", ram_en, 1'b1);
      chk("w_wr", ram_wr, 1'b1);
      chk("w_addr", ram_addr, 6'h0A);
      chk("w_wdata", ram_wdata, 8'hAA);
      r_req[0] = 0;
      tick();
      chk("w_no_rvalid", bus.rvalid_a, 1'b0);
      chk("w_hold_addr", ram_addr, 6'h0A);
      tick();

      // Simultaneous requests after reset: A first, B next, B's read data follows
      rst = 1; tick(); rst = 0;
      r_req[0] = 1; r_wr[0] = 1; r_addr[0] = 6'h0C; r_wd[0] = 8'hAB;
      r_req[1] = 1; r_wr[1] = 0; r_addr[1] = 6'h0A;
      tick();
      chk("sim_ack_a", bus.ack_a, 1'b1);
      chk("sim_ack_b0", bus.ack_b, 1'b0);
      r_req[0] = 0;
      tick();
      chk("sim_ack_b", bus.ack_b, 1'b1);
      r_req[1] = 0;
      tick();
      chk("sim_rvalid_b", bus.rvalid_b, 1'b1);
      chk("sim_rdata", bus.rdata, 8'hAA);
      tick();

      // Preload 0..7, then both read continuously
      run(16, 3, 0, 0, 0);
      run(3, 0, 0, 0, 0);
      run(8, 1, 1, 0, 4);
      chk("alt_en_cnt", n_en_obs, 8);
      chk("alt_ack_a_cnt", n_ack_obs[0], 4);
      chk("alt_ack_b_cnt", n_ack_obs[1], 4);
      run(3, 0, 0, 0, 0);

      // B alone, continuous reads
      run(8, 0, 1, 0, 0);
      chk("solo_ack_b_cnt", n_ack_obs[1], 4);
      chk("solo_en_cnt", n_en_obs, 4);
      run(3, 0, 0, 0, 0);

      // Reset right after A's read issues
      r_req[0] = 1; r_wr[0] = 0; r_addr[0] = 6'h02;
      tick();
      chk("rr_ack_a", bus.ack_a, 1'b1);
      rst = 1;
      r_addr[0] = 6'h03;
      r_req[1] = 1; r_wr[1] = 0; r_addr[1] = 6'h04;
      tick();
      chk("rr_rvalid_a", bus.rvalid_a, 1'b0);
      chk("rr_en", ram_en, 1'b0);
      chk("rr_addr", ram_addr, 6'h00);
      chk("rr_wdata", ram_wdata, 8'h00);
      rst = 0;
      tick();
      chk("rr_post_rvalid_a", bus.rvalid_a, 1'b0);
      chk("rr_post_ack_a", bus.ack_a, 1'b1);
      tick();
      chk("rr_post_ack_b", bus.ack_b, 1'b1);
      r_req[0] = 0; r_req[1] = 0;
      tick(); tick(); tick();

      // Random traffic against the scoreboard
      run(1000, 2, 2, 0, 0);
      run(4, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
